// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, funct3 codes, FSM states and flag indices for alu_seq.
package alu_seq_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [2:0] F3_SLL   = 3'b001;
  localparam logic [2:0] F3_SLT   = 3'b010;
  localparam logic [2:0] F3_SLTU  = 3'b011;
  localparam logic [2:0] F3_XOR   = 3'b100;
  localparam logic [2:0] F3_SR    = 3'b101;
  localparam logic [2:0] F3_OR    = 3'b110;
  localparam logic [2:0] F3_AND   = 3'b111;
  localparam logic [2:0] F3_MUL   = 3'b000;
  localparam logic [2:0] F3_MULHU = 3'b011;
  typedef enum logic {S_IDLE, S_MUL} state_e;
  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;
endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add multiplier, one step per cycle for N cycles.
// DONE pulses in the cycle whose rising edge completes the last step; RESULT is valid alongside it.
module alu_seq_mul #(
  parameter int N = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         HI,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         DONE,
  output logic [N-1:0] RESULT
);
  localparam int CW = $clog2(N) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic [N-1:0] mcand_q, mcand_d;
  logic hi_q, hi_d;
  logic [N:0] sum;
  // Upper half accumulates the multiplicand while the multiplier shifts out of the lower half
  always_comb begin
    sum = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_d = START ? {{N{1'b0}}, B} : cnt_q != '0 ? {sum, prod_q[N-1:1]} : prod_q;
    mcand_d = START ? A : mcand_q;
    hi_d = START ? HI : hi_q;
    cnt_d = START ? CW'(N) : cnt_q != '0 ? cnt_q - CW'(1) : cnt_q;
    DONE = cnt_q == CW'(1);
    RESULT = hi_q ? prod_d[2*N-1:N] : prod_d[N-1:0];
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      cnt_q <= '0;
      prod_q <= '0;
      mcand_q <= '0;
      hi_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      prod_q <= prod_d;
      mcand_q <= mcand_d;
      hi_q <= hi_d;
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked RV32I ALU with registered result, sticky {Z,N,C,V} flags and ILLEGAL.
// Define ALU_MULDIV_EN to add the iterative MUL/MULHU path (alu_seq_mul).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int N   = 32,
  parameter int SHW = $clog2(N)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [6:0]   OPCODE,
  input  logic [2:0]   FUNCT3,
  input  logic         FUNCT1,
  input  logic         FUNCTM,
  input  logic [N-1:0] RS1_DATA,
  input  logic [N-1:0] RS2_DATA,
  input  logic [N-1:0] PC,
  input  logic [11:0]  IMM12,
  input  logic [19:0]  U_IMM20,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [N-1:0] ALU_OUT,
  output logic [3:0]   FLAG_REG,
  output logic         ILLEGAL
);
  state_e state_q, state_d;
  logic out_valid_q, out_valid_d, illegal_q, illegal_d;
  logic [N-1:0] alu_out_q, alu_out_d;
  logic [3:0] flag_q, flag_d;
  logic is_op, is_imm, is_lui, is_auipc, is_mul, sub, bad, wr_cv, v;
  logic accept, start, alu_ld, ld, mul_done;
  logic [N-1:0] a, b, bb, imm_s, u_s, sra, res, mul_res, ld_val;
  logic [N:0] sum;
  logic [SHW-1:0] sh;
  assign IN_READY = state_q == S_IDLE && (!out_valid_q || OUT_READY);
  assign OUT_VALID = out_valid_q;
  assign ALU_OUT = alu_out_q;
  assign FLAG_REG = flag_q;
  assign ILLEGAL = illegal_q;
`ifdef ALU_MULDIV_EN
  assign is_mul = is_op && FUNCTM && (FUNCT3 == F3_MUL || FUNCT3 == F3_MULHU);
  alu_seq_mul #(.N(N)) u_mul (
    .CLK(CLK),
    .RST(RST),
    .START(start),
    .HI(FUNCT3 == F3_MULHU),
    .A(RS1_DATA),
    .B(RS2_DATA),
    .DONE(mul_done),
    .RESULT(mul_res)
  );
`else
  assign is_mul = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res = '0;
`endif
  always_comb begin
    is_op = OPCODE == OPC_OP;
    is_imm = OPCODE == OPC_OP_IMM;
    is_lui = OPCODE == OPC_LUI;
    is_auipc = OPCODE == OPC_AUIPC;
    imm_s = N'($signed(IMM12));
    u_s = N'($signed({U_IMM20, 12'b0}));
    a = is_auipc ? PC : RS1_DATA;
    b = is_op ? RS2_DATA : is_imm ? imm_s : u_s;
    sub = is_op && FUNCT1 && FUNCT3 == F3_ADD;
    bb = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, sub};
    v = (a[N-1] == bb[N-1]) && (sum[N-1] != a[N-1]);
    sh = is_imm ? IMM12[SHW-1:0] : RS2_DATA[SHW-1:0];
    sra = $signed(a) >>> sh;
    case (FUNCT3)
      F3_ADD:  res = sum[N-1:0];
      F3_SLL:  res = a << sh;
      F3_SLT:  res = {{(N-1){1'b0}}, $signed(a) < $signed(b)};
      F3_SLTU: res = {{(N-1){1'b0}}, a < b};
      F3_XOR:  res = a ^ b;
      F3_SR:   res = FUNCT1 ? sra : a >> sh;
      F3_OR:   res = a | b;
      default: res = a & b;
    endcase
    if (is_lui) res = u_s;
    else if (is_auipc) res = sum[N-1:0];
    // Under OP-IMM, FUNCT1 is immediate bit 10, so only the SLLI encoding can make it illegal
    bad = !(is_op || is_imm || is_lui || is_auipc)
        || (is_op && FUNCTM && !is_mul)
        || (is_op && !FUNCTM && FUNCT1 && FUNCT3 != F3_ADD && FUNCT3 != F3_SR)
        || (is_imm && FUNCT1 && FUNCT3 == F3_SLL);
    wr_cv = is_auipc || (((is_op && !FUNCTM) || is_imm) && FUNCT3 == F3_ADD);
  end
  always_comb begin
    accept = IN_VALID && IN_READY;
    start = accept && is_mul;
    alu_ld = accept && !is_mul;
    ld = alu_ld || mul_done;
    ld_val = mul_done ? mul_res : bad ? '0 : res;
    out_valid_d = ld || (out_valid_q && !OUT_READY);
    alu_out_d = ld ? ld_val : alu_out_q;
    illegal_d = ld ? alu_ld && bad : illegal_q;
    flag_d = flag_q;
    if (ld && !(alu_ld && bad)) begin
      flag_d[FLG_Z] = ld_val == '0;
      flag_d[FLG_N] = ld_val[N-1];
      flag_d[FLG_C] = alu_ld && wr_cv ? sum[N] : flag_q[FLG_C];
      flag_d[FLG_V] = alu_ld && wr_cv ? v : flag_q[FLG_V];
    end
    state_d = state_q == S_IDLE && start ? S_MUL : state_q == S_MUL && mul_done ? S_IDLE : state_q;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= S_IDLE;
      out_valid_q <= 1'b0;
      alu_out_q <= '0;
      flag_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_valid_q <= out_valid_d;
      alu_out_q <= alu_out_d;
      flag_q <= flag_d;
      illegal_q <= illegal_d;
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq (N=32, plus an N=64 instance for LUI/AUIPC widths);
// a behavioural reference model is compared against the DUT on every falling edge.
module tb_alu_seq;
  localparam logic [6:0] OP = 7'h33, OPI = 7'h13, LUI = 7'h37, AUIPC = 7'h17;
  localparam int K_KEEP = 0, K_CV = 1, K_ILL = 2, K_MUL = 3;
  localparam int MUL_LAT = 32;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, f1 = 0, fm = 0;
  logic [6:0] opcode = 0;
  logic [2:0] f3 = 0;
  logic [31:0] rs1 = 0, rs2 = 0, pc = 0;
  logic [11:0] imm = 0;
  logic [19:0] ui = 0;
  logic in_ready, out_valid, ill, rdy64, ov64, il64;
  logic [31:0] alu_out;
  logic [63:0] out64;
  logic [3:0] flag, fl64;
  int n_chk = 0, n_pass = 0;
  logic m_valid = 0, m_ill = 0;
  logic [31:0] m_out = 0, m_pend = 0;
  logic [3:0] m_flag = 0;
  int m_busy = 0;

  always #5 clk = ~clk;

  alu_seq #(.N(32)) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .OPCODE(opcode), .FUNCT3(f3), .FUNCT1(f1), .FUNCTM(fm),
    .RS1_DATA(rs1), .RS2_DATA(rs2), .PC(pc), .IMM12(imm), .U_IMM20(ui),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .ALU_OUT(alu_out),
    .FLAG_REG(flag), .ILLEGAL(ill)
  );

  alu_seq #(.N(64)) dut64 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(rdy64),
    .OPCODE(opcode), .FUNCT3(f3), .FUNCT1(f1), .FUNCTM(fm),
    .RS1_DATA({32'b0, rs1}), .RS2_DATA({32'b0, rs2}), .PC({32'b0, pc}), .IMM12(imm), .U_IMM20(ui),
    .OUT_VALID(ov64), .OUT_READY(out_ready), .ALU_OUT(out64),
    .FLAG_REG(fl64), .ILLEGAL(il64)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic m_ready();
    return m_busy == 0 && (!m_valid || out_ready);
  endfunction

  function automatic void ref_alu(input logic [6:0] opc, input logic [2:0] op3, input logic s1, sm,
                                  input logic [31:0] x, y, p, input logic [11:0] im, input logic [19:0] uu,
                                  output logic [31:0] r, output int kind, output logic c, output logic v);
    logic [31:0] b, uv;
    int sh;
    longint s;
`ifdef ALU_MULDIV_EN
    logic [63:0] prod;
`endif
    r = 0; kind = K_KEEP; c = 0; v = 0;
    uv = {uu, 12'h000};
    b = (opc == OP) ? y : {{20{im[11]}}, im};
    sh = int'(b[4:0]);
    if (opc == LUI) r = uv;
    else if (opc == AUIPC) begin
      r = p + uv; kind = K_CV;
      c = (longint'(p) + longint'(uv)) > longint'(32'hFFFF_FFFF);
      s = longint'($signed(p)) + longint'($signed(uv));
      v = s != longint'($signed(r));
    end else if (opc == OP && sm) begin
`ifdef ALU_MULDIV_EN
      prod = 64'(x) * 64'(y);
      if (op3 == 3'd0) begin r = prod[31:0]; kind = K_MUL; end
      else if (op3 == 3'd3) begin r = prod[63:32]; kind = K_MUL; end
      else kind = K_ILL;
`else
      kind = K_ILL;
`endif
    end else if (opc == OP || opc == OPI) begin
      if ((opc == OP && s1 && op3 != 3'd0 && op3 != 3'd5) || (opc == OPI && s1 && op3 == 3'd1)) kind = K_ILL;
      else if (op3 == 3'd0 && opc == OP && s1) begin
        r = x - b; kind = K_CV; c = x >= b;
        s = longint'($signed(x)) - longint'($signed(b));
        v = s != longint'($signed(r));
      end else if (op3 == 3'd0) begin
        r = x + b; kind = K_CV;
        c = (longint'(x) + longint'(b)) > longint'(32'hFFFF_FFFF);
        s = longint'($signed(x)) + longint'($signed(b));
        v = s != longint'($signed(r));
      end else if (op3 == 3'd1) r = x << sh;
      else if (op3 == 3'd2) r = ($signed(x) < $signed(b)) ? 32'd1 : 32'd0;
      else if (op3 == 3'd3) r = (x < b) ? 32'd1 : 32'd0;
      else if (op3 == 3'd4) r = x ^ b;
      else if (op3 == 3'd5 && s1) r = $signed(x) >>> sh;
      else if (op3 == 3'd5) r = x >> sh;
      else if (op3 == 3'd6) r = x | b;
      else r = x & b;
    end else kind = K_ILL;
  endfunction

  initial forever begin
    logic [31:0] r;
    int kind;
    logic c, v, acc;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_valid = 0; m_ill = 0; m_out = 0; m_flag = 0; m_busy = 0;
    end else begin
      acc = in_valid && m_ready();
      if (m_valid && out_ready) m_valid = 0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_out = m_pend; m_ill = 0; m_valid = 1;
          m_flag[3] = m_pend == 0; m_flag[2] = m_pend[31];
        end
      end
      if (acc) begin
        ref_alu(opcode, f3, f1, fm, rs1, rs2, pc, imm, ui, r, kind, c, v);
        if (kind == K_MUL) begin m_busy = MUL_LAT; m_pend = r; end
        else begin
          m_valid = 1; m_out = r; m_ill = kind == K_ILL;
          if (kind != K_ILL) m_flag = {r == 0, r[31], kind == K_CV ? {c, v} : m_flag[1:0]};
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("in_ready", in_ready, m_ready());
    chk("out_valid", out_valid, m_valid);
    chk("alu_out", alu_out, m_out);
    chk("flag_reg", flag, m_flag);
    chk("illegal", ill, m_ill);
  end

  task automatic send(input logic [6:0] o, input logic [2:0] f, input logic a1, am,
                      input logic [31:0] x, y, input logic [11:0] im = 0,
                      input logic [19:0] uu = 0, input logic [31:0] p = 0);
    int t;
    opcode = o; f3 = f; f1 = a1; fm = am; rs1 = x; rs2 = y; imm = im; ui = uu; pc = p;
    in_valid = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!in_ready && t < 100);
    if (!in_ready) begin
      n_chk++;
      $display("FAIL send_timeout: in_ready low for %0d cycles", t);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_out", alu_out, 0);
    chk("rst_flag", flag, 0);
    chk("rst_illegal", ill, 0);
    @(negedge clk); #1 rst = 0; out_ready = 1;
    send(OP, 3'd0, 0, 0, 32'h7FFF_FFFF, 32'h1);
    chk("add_ovf_out", alu_out, 32'h8000_0000);
    chk("add_ovf_flag", flag, 4'b0101);
    chk("add_ovf_ill", ill, 0);
    chk("add_ovf_valid", out_valid, 1);
    send(OP, 3'd0, 1, 0, 32'd5, 32'd5);
    chk("sub_zero_out", alu_out, 0);
    chk("sub_zero_flag", flag, 4'b1010);
    send(OP, 3'd4, 0, 0, 32'hF0, 32'h0F);
    chk("xor_out", alu_out, 32'hFF);
    chk("xor_flag", flag, 4'b0010);
    send(7'h7F, 3'd0, 0, 0, 32'h1234, 32'h1);
    chk("bad_opc_out", alu_out, 0);
    chk("bad_opc_ill", ill, 1);
    chk("bad_opc_flag", flag, 4'b0010);
    send(OPI, 3'd0, 0, 0, 32'd10, 0, 12'hFFD);
    send(OP, 3'd2, 0, 0, 32'hFFFF_FFFF, 32'd1);
    send(OP, 3'd3, 0, 0, 32'hFFFF_FFFF, 32'd1);
    send(OPI, 3'd1, 0, 0, 32'd1, 0, 12'd31);
    send(OPI, 3'd5, 1, 0, 32'h8000_0000, 0, 12'h404);
    chk("srai_out", alu_out, 32'hF800_0000);
    send(OP, 3'd5, 0, 0, 32'h8000_0000, 32'd4);
    send(OP, 3'd0, 1, 0, 32'd3, 32'd5);
    chk("sub_borrow_out", alu_out, 32'hFFFF_FFFE);
    chk("sub_borrow_flag", flag, 4'b0100);
    send(OP, 3'd0, 1, 0, 32'h8000_0000, 32'd1);
    chk("sub_ovf_flag", flag, 4'b0011);
    send(OPI, 3'd7, 0, 0, 32'hFF, 0, 12'h0F0);
    send(OPI, 3'd6, 0, 0, 32'h0, 0, 12'h800);
    send(OP, 3'd4, 1, 0, 32'h5, 32'h3);
    chk("bad_funct_ill", ill, 1);
    send(OPI, 3'd1, 1, 0, 32'h5, 0, 12'h401);
    send(OP, 3'd1, 0, 0, 32'd3, 32'd33);
    chk("sll_mask_out", alu_out, 32'd6);
    @(posedge clk); #1;
    out_ready = 0;
    send(OP, 3'd6, 0, 0, 32'd1, 32'd2);
    chk("bp_first_out", alu_out, 32'd3);
    opcode = OP; f3 = 3'd7; f1 = 0; fm = 0; rs1 = 32'hC; rs2 = 32'hA;
    in_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", alu_out, 32'd3);
    end
    #1 out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    chk("bp_second_out", alu_out, 32'd8);
    chk("bp_valid_kept", out_valid, 1);
    send(LUI, 3'd0, 0, 0, 0, 0, 0, 20'h80000);
    chk("lui32_out", alu_out, 32'h8000_0000);
    chk("lui64_out", out64, 64'hFFFF_FFFF_8000_0000);
    chk("lui64_zn", fl64[3:2], 2'b01);
    chk("lui64_ill", il64, 0);
    send(AUIPC, 3'd0, 0, 0, 0, 0, 0, 20'h1, 32'h1000);
    chk("auipc32_out", alu_out, 32'h2000);
    chk("auipc64_out", out64, 64'h2000);
    chk("auipc64_valid", ov64, 1);
    chk("auipc64_ready", rdy64, 1);
    send(OP, 3'd3, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef ALU_MULDIV_EN
    for (int k = 1; k <= MUL_LAT; k++) begin
      @(posedge clk); #1;
      if (k == MUL_LAT - 1) chk("mulhu_early", out_valid, 0);
    end
    chk("mulhu_valid", out_valid, 1);
    chk("mulhu_out", alu_out, 32'hFFFF_FFFE);
    chk("mulhu_ill", ill, 0);
    send(OP, 3'd0, 0, 1, 32'd7, 32'd6);
    for (int k = 1; k <= MUL_LAT; k++) begin @(posedge clk); #1; end
    chk("mul_out", alu_out, 32'd42);
`else
    chk("mulhu_off_out", alu_out, 0);
    chk("mulhu_off_ill", ill, 1);
    chk("mulhu_off_valid", out_valid, 1);
`endif
    send(OP, 3'd0, 0, 1, 32'd3, 32'd3);
    repeat (4) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("rstmul_valid", out_valid, 0);
    chk("rstmul_out", alu_out, 0);
    chk("rstmul_flag", flag, 0);
    @(negedge clk); #1 rst = 0;
    repeat (40) @(posedge clk);
    #1;
    chk("rstmul_no_result", out_valid, 0);
    chk("rstmul_ready", in_ready, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 32-bit RV32I ALU top.
- Decodes OP / OP-IMM / LUI / AUIPC operands internally and evaluates the result.
- Holds the result in a registered output stage with valid/ready flow control and a sticky flag register.
- Optionally adds an iterative shift-add multiplier (RV M subset).
- Sits between the decode stage and the writeback mux of the core pipeline.

Parameters:
- N, 32, datapath width; N >= 32 and a power of two.
- SHW, $clog2(N), shift-amount width (derived; do not override).

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- IN_VALID  in  1  operation presented
- IN_READY  out  1  block can accept an operation this cycle
- OPCODE  in  7  RISC-V major opcode
- FUNCT3  in  3  instruction funct3
- FUNCT1  in  1  instr[30]; selects SUB / SRA / SRAI
- FUNCTM  in  1  instr[25]; selects the M-extension group under OP
- RS1_DATA  in  N  source 1
- RS2_DATA  in  N  source 2
- PC  in  N  instruction address
- IMM12  in  12  I-type immediate
- U_IMM20  in  20  U-type immediate
- OUT_VALID  out  1  ALU_OUT holds an unconsumed result
- OUT_READY  in  1  consumer takes the result
- ALU_OUT  out  N  registered result
- FLAG_REG  out  4  {Z,N,C,V}, registered
- ILLEGAL  out  1  registered; high with a result whose op was unsupported

Behaviour:
- Reset (async, immediate): OUT_VALID=0, ALU_OUT=0, FLAG_REG=0, ILLEGAL=0, FSM=IDLE, multiplier counter/accumulators=0. A multiply in flight is discarded.
- Handshake:
  - IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY).
  - Transfer occurs when IN_VALID && IN_READY at a rising edge.
  - OUT_VALID clears on OUT_VALID && OUT_READY unless a new result loads on the same edge; a new result has priority and keeps OUT_VALID=1.
  - Once OUT_VALID=1, ALU_OUT and FLAG_REG stay stable until consumed.
- Operand decode:
  - IMM12 sign-extended to N.
  - LUI result = sign-extend({U_IMM20,12'b0}).
  - AUIPC result = PC + that value.
  - Shift amount: OP-IMM uses IMM12[SHW-1:0]; OP uses RS2_DATA[SHW-1:0].
- Ops: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND, and their immediate forms. SUB is only valid under OP. Arithmetic is modulo 2^N.
- Single-cycle path: result loads at the accepting edge and is visible (OUT_VALID=1) in the next cycle. Latency 1. Sustained throughput is 1/cycle when OUT_READY is held high.
- Flags (updated only when a result loads):
  - Z = (ALU_OUT==0); N = ALU_OUT[N-1].
  - C and V are written only by add/sub/AUIPC; all other ops retain the previous C and V.
  - C is the carry-out of A + B (ADD) or A + ~B + 1 (SUB), so C=1 means no borrow.
  - V is signed overflow.
- Unsupported opcode/funct combination: loads ALU_OUT=0 with ILLEGAL=1; FLAG_REG is unchanged. ILLEGAL=0 for every supported op.
- FSM states: IDLE, MUL.
  - IDLE -> MUL on acceptance of a multiply; only when the macro is defined.
  - MUL -> IDLE on the edge the counter reaches 0; the result loads on that edge.

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined, multiply ops (OPCODE=OP, FUNCTM=1):
  - FUNCT3=000 (MUL) returns the low N bits of the product.
  - FUNCT3=011 (MULHU) returns the high N bits of the unsigned 2N-bit product.
  - Execution: one shift-add step per cycle for N cycles. The result is visible N cycles after the accepting edge, and IN_READY=0 during MUL.
  - Flags: Z and N updated; C and V retained.
  - Other FUNCT3 values with FUNCTM=1 are illegal.
- Undefined: every FUNCTM=1 op under OP is illegal, completes in 1 cycle, and the MUL state and datapath are not synthesised.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams (OP, OP_IMM, LUI, AUIPC);
  - funct3 localparams;
  - the FSM state enum typedef;
  - the flag bit index constants (Z=3, N=2, C=1, V=0).
- One sub-module, alu_seq_mul: the iterative multiplier, parametrised by N, with START/DONE handshake. It is instantiated only under ALU_MULDIV_EN.

Test Plan:
- Reset mid-multiply (macro on, N=32): assert RST on cycle 5 of a MUL -> immediate OUT_VALID=0, IN_READY=1 after release, no result ever produced.
- ADD 0x7FFFFFFF + 1 with OUT_READY=1 -> next cycle ALU_OUT=0x80000000, FLAG_REG=0b0101 (N,V), ILLEGAL=0.
- SUB 5 - 5 -> ALU_OUT=0, FLAG_REG=0b1010 (Z,C). Follow with XOR 0xF0 ^ 0x0F -> 0xFF, Z=0, N=0, C and V retained (=1,0).
- Backpressure: OUT_READY=0 with two ops queued -> IN_READY=0 after the first loads and ALU_OUT holds. Raise OUT_READY -> the second is accepted on the same edge as the first is consumed, and OUT_VALID stays 1.
- LUI U_IMM20=0x80000 at N=64 -> ALU_OUT=0xFFFFFFFF80000000. AUIPC PC=0x1000, U_IMM20=0x1 -> 0x2000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF (macro on) -> result visible exactly 32 cycles after acceptance, ALU_OUT=0xFFFFFFFE. With the macro off, the same op gives ALU_OUT=0 and ILLEGAL=1 after 1 cycle.
